// File: rtl/wb_sram_slave_pkg.sv
// Shared Wishbone cycle/burst type codes and small decode helpers used by the
// SRAM slave and by bus masters that talk to it.
package wb_sram_slave_pkg;

  // Cycle type identifiers (CTI)
  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_INC     = 3'b010;
  localparam logic [2:0] WB_CTI_END     = 3'b111;

  // Burst type extensions (BTE)
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
  localparam logic [1:0] WB_BTE_WRAP4   = 2'b01;
  localparam logic [1:0] WB_BTE_WRAP8   = 2'b10;
  localparam logic [1:0] WB_BTE_WRAP16  = 2'b11;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 30;
  localparam int WB_SEL_W  = 4;

  // Reduced view of the CTI field; reserved codes behave like classic.
  typedef enum logic [1:0] {
    CYC_CLASSIC = 2'd0,
    CYC_INC     = 2'd1,
    CYC_END     = 2'd2
  } wb_cyc_kind_e;

  function automatic wb_cyc_kind_e decode_cti(input logic [2:0] cti);
    case (cti)
      WB_CTI_INC: return CYC_INC;
      WB_CTI_END: return CYC_END;
      default:    return CYC_CLASSIC;
    endcase
  endfunction

  // Low address bits that wrap for a wrapping burst; zero for linear.
  function automatic logic [3:0] bte_wrap_mask(input logic [1:0] bte);
    case (bte)
      WB_BTE_WRAP4:  return 4'h3;
      WB_BTE_WRAP8:  return 4'h7;
      WB_BTE_WRAP16: return 4'hF;
      default:       return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/wb_sram_slave_bram_sel32.sv
// Simple 32-bit word RAM with per-byte write enables and a registered read
// port. Kept free of bus logic so synthesis can map it onto block RAM.
module bram_sel32 #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [31:0]          wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**ADDR_BITS];
  logic [31:0] rdata_q;

  // Byte-lane write; array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read register only loads when asked, so the bus sees stable data while
  // the slave is idle or the master stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone memory target: single and incrementing-burst access to a block RAM
// with a programmable first-beat wait count, wrap/linear burst addressing and
// bus errors for out-of-range or out-of-sequence addresses.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a request; the only state that samples a new one
// WAIT    | counting first-beat wait states, RAM read issued on exit
// BEAT    | acking beats; advances ptr on incrementing bursts
// ERR     | signalling err for the first request cycle
// RECOVER | one dead cycle between accesses
module wb_sram_slave
  import wb_sram_slave_pkg::*;
#(
  parameter int          ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [29:0] wbs_addr_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_data_i,
  output logic [31:0] wbs_data_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int                UP_W      = 30 - ADDR_BITS;
  localparam logic [UP_W-1:0]   BASE_UP   = BASE_ADDR[31:ADDR_BITS+2];
  localparam logic [3:0]        WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_BEAT    = 3'd2;
  localparam logic [2:0] S_ERR     = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 first_q, first_d;

  logic                 req;
  logic                 in_range;
  logic [ADDR_BITS-1:0] req_idx;
  logic [ADDR_BITS-1:0] wrap_mask;
  logic [ADDR_BITS-1:0] ptr_inc;
  logic [ADDR_BITS-1:0] ptr_next;
  logic                 next_valid;
  logic                 advance;
  logic                 burst_mismatch;
  wb_cyc_kind_e         cyc_kind;

  logic                 ack_r;
  logic                 err_r;
  logic                 mem_we;
  logic                 mem_re;
  logic [ADDR_BITS-1:0] mem_raddr;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign in_range = (wbs_addr_i[29:ADDR_BITS] == BASE_UP);
  assign req_idx  = wbs_addr_i[ADDR_BITS-1:0];
  assign cyc_kind = decode_cti(wbs_cti_i);

  // Wrapping bursts only carry into the low 2/3/4 bits; linear carries through.
  assign wrap_mask = (wbs_bte_i == WB_BTE_LINEAR) ? '1
                   : {{(ADDR_BITS-4){1'b0}}, bte_wrap_mask(wbs_bte_i)};
  assign ptr_inc   = ptr_q + ADDR_BITS'(1);
  assign ptr_next  = (ptr_q & ~wrap_mask) | (ptr_inc & wrap_mask);

  // A linear burst may not run off the top of the RAM window.
  assign next_valid = !((wbs_bte_i == WB_BTE_LINEAR) && (&ptr_q));
  assign advance    = (cyc_kind == CYC_INC) && next_valid;

  // After the first beat, every beat must present the address we expect next.
  assign burst_mismatch = !first_q && (wbs_addr_i != {BASE_UP, ptr_q});

  // State, pointer and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Next-state logic; dropping cyc abandons whatever is in flight.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (!wbs_cyc_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (!in_range) begin
              state_d = S_ERR;
            end else begin
              ptr_d   = req_idx;
              first_d = 1'b1;
              if (WAIT_STATES == 0) begin
                state_d = S_BEAT;
              end else begin
                cnt_d   = WAIT_LOAD;
                state_d = S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = S_BEAT;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_BEAT: begin
          if (req) begin
            if (burst_mismatch) begin
              state_d = S_RECOVER;
            end else if (advance) begin
              ptr_d   = ptr_next;
              first_d = 1'b0;
            end else begin
              state_d = S_RECOVER;
            end
          end
        end
        S_ERR: begin
          if (req) begin
            state_d = S_RECOVER;
          end
        end
        S_RECOVER: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Response flags and RAM control. The read port is loaded on entry to BEAT
  // and again with the next word on every advancing beat, so read bursts
  // stream without bubbles.
  always_comb begin
    ack_r     = 1'b0;
    err_r     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_raddr = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (req && in_range && (WAIT_STATES == 0)) begin
          mem_re    = 1'b1;
          mem_raddr = req_idx;
        end
      end
      S_WAIT: begin
        if (wbs_cyc_i && (cnt_q == 4'd0)) begin
          mem_re = 1'b1;
        end
      end
      S_BEAT: begin
        ack_r = !burst_mismatch;
        err_r = burst_mismatch;
        if (req && !burst_mismatch) begin
          mem_we = wbs_we_i;
          if (advance) begin
            mem_re    = 1'b1;
            mem_raddr = ptr_next;
          end
        end
      end
      S_ERR:   err_r = 1'b1;
      default: ;
    endcase
  end

  assign wbs_ack_o = ack_r & req;
  assign wbs_err_o = err_r & req;

  bram_sel32 #(
    .ADDR_BITS (ADDR_BITS)
  ) u_bram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .be_i    (wbs_sel_i),
    .waddr_i (ptr_q),
    .wdata_i (wbs_data_i),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (wbs_data_o)
  );

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: the driver runs a fixed cycle schedule and
// queues the response it requires in each cycle; the monitor pops and checks
// on the falling edge and flags any response nobody asked for.
module tb_wb_sram_slave;
  import wb_sram_slave_pkg::*;

  localparam int          WS    = 1;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [29:0] WBASE = 30'h0000_4000;

  localparam int K_ACK   = 0;
  localparam int K_ERR   = 1;
  localparam int K_QUIET = 2;

  localparam logic [31:0] W4 = 32'hA0A0_0004;
  localparam logic [31:0] W5 = 32'hB1B1_0005;
  localparam logic [31:0] W6 = 32'hC2C2_0006;
  localparam logic [31:0] W7 = 32'hD3D3_0007;

  logic        clk;
  logic        rst_n;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [29:0] wbs_addr_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic [31:0] wbs_data_i;
  logic [31:0] wbs_data_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  typedef struct {
    int          cyc;
    int          kind;
    bit          chk;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          cyc_cnt = 0;
  int          checks  = 0;
  int          errors  = 0;
  bit          done    = 0;
  logic [29:0] ba [8];
  logic [31:0] bw [8];
  logic [31:0] bx [8];

  wb_sram_slave #(
    .ADDR_BITS   (10),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (WS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_addr_i (wbs_addr_i),
    .wbs_cti_i  (wbs_cti_i),
    .wbs_bte_i  (wbs_bte_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_data_i (wbs_data_i),
    .wbs_data_o (wbs_data_o),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_err_o  (wbs_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [29:0] wa(input int idx);
    return WBASE + 30'(idx);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int c, input int kind, input bit chk,
                          input logic [31:0] d, input string nm);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    e.chk  = chk;
    e.data = d;
    e.name = nm;
    q.push_back(e);
  endtask

  // Runs n beats from ba/bw, requiring bx on reads. err_beat marks the beat
  // that must be answered with err (beat 0 = out-of-range, no wait states).
  // The master keeps stb high one cycle past the last response.
  task automatic burst(input int n, input bit we, input logic [1:0] bte,
                       input logic [3:0] sel, input int stall_after,
                       input int stall_len, input int err_beat, input string nm);
    int c;
    bit is_err;
    for (int i = 0; i < n; i++) begin
      is_err     = (i == err_beat);
      wbs_cyc_i  = 1'b1;
      wbs_stb_i  = 1'b1;
      wbs_addr_i = ba[i];
      wbs_we_i   = we;
      wbs_sel_i  = sel;
      wbs_bte_i  = bte;
      wbs_data_i = bw[i];
      wbs_cti_i  = (n == 1) ? WB_CTI_CLASSIC : ((i == n - 1) ? WB_CTI_END : WB_CTI_INC);
      if (i == 0) c = cyc_cnt + 1 + (is_err ? 0 : WS);
      else        c = cyc_cnt;
      push_exp(c, is_err ? K_ERR : K_ACK, !we && !is_err, bx[i],
               $sformatf("%s beat%0d", nm, i));
      repeat (c + 1 - cyc_cnt) step();
      if (is_err) break;
      if (i == stall_after && stall_len > 0) begin
        wbs_stb_i = 1'b0;
        repeat (stall_len) step();
      end
    end
    step();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    step();
    step();
  endtask

  task automatic single(input logic [29:0] a, input bit we, input logic [3:0] sel,
                        input logic [31:0] wd, input bit is_err,
                        input logic [31:0] rd, input string nm);
    ba[0] = a;
    bw[0] = wd;
    bx[0] = rd;
    burst(1, we, WB_BTE_LINEAR, sel, -1, 0, is_err ? 0 : -1, nm);
  endtask

  // Stimulus
  initial begin
    rst_n      = 1'b0;
    wbs_cyc_i  = 1'b0;
    wbs_stb_i  = 1'b0;
    wbs_addr_i = '0;
    wbs_cti_i  = WB_CTI_CLASSIC;
    wbs_bte_i  = WB_BTE_LINEAR;
    wbs_sel_i  = 4'h0;
    wbs_we_i   = 1'b0;
    wbs_data_i = '0;
    repeat (3) step();
    rst_n = 1'b1;
    push_exp(cyc_cnt, K_QUIET, 1'b1, 32'h0, "reset outputs");
    step();
    step();

    // classic write then read of word 5
    single(wa(5), 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, "wr5");
    single(wa(5), 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, "rd5");

    // byte-lane write into a cleared word
    single(wa(3), 1'b1, 4'hF, 32'h0000_0000, 1'b0, 32'h0, "clr3");
    single(wa(3), 1'b1, 4'b0100, 32'h1122_3344, 1'b0, 32'h0, "lane3");
    single(wa(3), 1'b0, 4'hF, 32'h0, 1'b0, 32'h0022_0000, "rd lane3");

    // linear write burst 4..7
    ba[0] = wa(4); ba[1] = wa(5); ba[2] = wa(6); ba[3] = wa(7);
    bw[0] = W4;    bw[1] = W5;    bw[2] = W6;    bw[3] = W7;
    burst(4, 1'b1, WB_BTE_LINEAR, 4'hF, -1, 0, -1, "wrburst4");

    // wrap4 read from word 6 -> 6,7,4,5
    ba[0] = wa(6); ba[1] = wa(7); ba[2] = wa(4); ba[3] = wa(5);
    bx[0] = W6;    bx[1] = W7;    bx[2] = W4;    bx[3] = W5;
    burst(4, 1'b0, WB_BTE_WRAP4, 4'hF, -1, 0, -1, "wrap4");

    // out-of-range read and write, then confirm word 5 untouched
    single(30'h0000_0006, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, "oor rd");
    single(30'h0000_0005, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0, "oor wr");
    single(wa(5), 1'b0, 4'hF, 32'h0, 1'b0, W5, "rd5 after oor");

    // mid-burst address jump on the third beat
    ba[0] = wa(4); ba[1] = wa(5); ba[2] = wa(9); ba[3] = wa(10);
    bx[0] = W4;    bx[1] = W5;    bx[2] = 32'h0; bx[3] = 32'h0;
    burst(4, 1'b0, WB_BTE_LINEAR, 4'hF, -1, 0, 2, "midburst");

    // drop cyc during the wait state of a write
    wbs_cyc_i  = 1'b1;
    wbs_stb_i  = 1'b1;
    wbs_addr_i = wa(7);
    wbs_we_i   = 1'b1;
    wbs_sel_i  = 4'hF;
    wbs_cti_i  = WB_CTI_CLASSIC;
    wbs_data_i = 32'h0BAD_F00D;
    step();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    step();
    step();
    single(wa(7), 1'b0, 4'hF, 32'h0, 1'b0, W7, "rd7 after cyc drop");

    // reset asserted during the wait state of a read
    wbs_cyc_i  = 1'b1;
    wbs_stb_i  = 1'b1;
    wbs_addr_i = wa(4);
    wbs_cti_i  = WB_CTI_CLASSIC;
    step();
    rst_n = 1'b0;
    push_exp(cyc_cnt, K_QUIET, 1'b1, 32'h0, "reset in wait");
    step();
    step();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    rst_n     = 1'b1;
    step();
    step();
    single(wa(6), 1'b0, 4'hF, 32'h0, 1'b0, W6, "rd6 after reset");

    // linear write burst 8..11 with a 2-cycle stb stall between beats 2 and 3
    ba[0] = wa(8);         ba[1] = wa(9);         ba[2] = wa(10);        ba[3] = wa(11);
    bw[0] = 32'h8888_0008; bw[1] = 32'h9999_0009; bw[2] = 32'hAAAA_000A; bw[3] = 32'hBBBB_000B;
    burst(4, 1'b1, WB_BTE_LINEAR, 4'hF, 1, 2, -1, "stallwr");
    bx[0] = 32'h8888_0008; bx[1] = 32'h9999_0009; bx[2] = 32'hAAAA_000A; bx[3] = 32'hBBBB_000B;
    burst(4, 1'b0, WB_BTE_LINEAR, 4'hF, -1, 0, -1, "stallrd");

    step();
    done = 1'b1;
  end

  // Scoreboard monitor
  initial begin
    exp_t  e;
    bit    ok;
    string kn;
    while (!done) begin
      @(negedge clk);
      if (q.size() > 0 && q[0].cyc < cyc_cnt) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: slot at cycle %0d passed unchecked (now %0d)", e.name, e.cyc, cyc_cnt);
      end
      if (q.size() > 0 && q[0].cyc == cyc_cnt) begin
        e = q.pop_front();
        checks++;
        case (e.kind)
          K_ACK: begin
            ok = wbs_ack_o && !wbs_err_o && (!e.chk || wbs_data_o == e.data);
            kn = "ack";
          end
          K_ERR: begin
            ok = wbs_err_o && !wbs_ack_o;
            kn = "err";
          end
          default: begin
            ok = !wbs_ack_o && !wbs_err_o && (!e.chk || wbs_data_o == e.data);
            kn = "quiet";
          end
        endcase
        if (!ok) begin
          errors++;
          $display("FAIL %s @cycle %0d: got ack=%0b err=%0b data=%08h, required %s data=%08h (checked=%0b)",
                   e.name, cyc_cnt, wbs_ack_o, wbs_err_o, wbs_data_o, kn, e.data, e.chk);
        end
      end else if (wbs_ack_o || wbs_err_o) begin
        checks++;
        errors++;
        $display("FAIL unexpected response @cycle %0d: got ack=%0b err=%0b, required none",
                 cyc_cnt, wbs_ack_o, wbs_err_o);
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
